// File: rtl/data_mem_arbiter.sv
// Round-robin two-port arbiter sequencing single-cycle accesses to the data memory.
// Define MEM_ALIGN_CHECK_EN to flag misaligned/out-of-range requests on the err output.
module data_mem_arbiter #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int MEM_BYTES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Write_Data,
  output logic              MemWrite,
  output logic              MemRead,
`ifdef MEM_ALIGN_CHECK_EN
  output logic              err,
`endif
  input  logic [DATA_W-1:0] Read_Data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_reg, state_next;
  logic              last_grant_reg;
  logic              port_reg;
  logic              write_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg [2];
  logic [1:0]        rvalid_vec;

  logic              accept;
  logic              grant_sel;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              access_ok;

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    grant_sel  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          accept     = 1'b1;
          // On contention the port that did not win last time goes first.
          if (req0_valid && req1_valid) grant_sel = ~last_grant_reg;
          else                          grant_sel = req1_valid;
          state_next = ACCESS;
        end
      end
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign req0_ready = accept && !grant_sel;
  assign req1_ready = accept &&  grant_sel;

  assign sel_write = grant_sel ? req1_write : req0_write;
  assign sel_addr  = grant_sel ? req1_addr  : req0_addr;
  assign sel_wdata = grant_sel ? req1_wdata : req0_wdata;

`ifdef MEM_ALIGN_CHECK_EN
  logic sel_illegal;
  logic illegal_reg;

  assign sel_illegal = (sel_addr[2:0] != 3'd0) || (sel_addr > ADDR_W'(MEM_BYTES - 8));

  always_ff @(posedge clk) begin
    if (reset)       illegal_reg <= 1'b0;
    else if (accept) illegal_reg <= sel_illegal;
  end

  assign access_ok = (state_reg == ACCESS) && !illegal_reg;
  assign err       = (state_reg == RESP) && illegal_reg;
`else
  assign access_ok = (state_reg == ACCESS);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      port_reg       <= 1'b0;
      write_reg      <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        last_grant_reg <= grant_sel;
        port_reg       <= grant_sel;
        write_reg      <= sel_write;
        addr_reg       <= sel_addr;
        wdata_reg      <= sel_wdata;
      end
    end
  end

  // The latch drives the memory bus directly, so the address persists after ACCESS.
  assign Mem_Addr   = addr_reg;
  assign Write_Data = wdata_reg;
  assign MemWrite   = access_ok &&  write_reg;
  assign MemRead    = access_ok && !write_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      always_ff @(posedge clk) begin
        if (reset) begin
          rdata_reg[gi] <= '0;
        end else if (state_reg == ACCESS && port_reg == 1'(gi)) begin
          // A rejected access clears the port's result instead of sampling memory.
          if (!access_ok)      rdata_reg[gi] <= '0;
          else if (!write_reg) rdata_reg[gi] <= Read_Data;
        end
      end
      assign rvalid_vec[gi] = (state_reg == RESP) && (port_reg == 1'(gi));
    end
  endgenerate

  assign req0_rvalid = rvalid_vec[0];
  assign req1_rvalid = rvalid_vec[1];
  assign req0_rdata  = rdata_reg[0];
  assign req1_rdata  = rdata_reg[1];

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with an 8-doubleword memory model.
// Error-flag cases run only when MEM_ALIGN_CHECK_EN is defined.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_write, req0_ready, req0_rvalid;
  logic [63:0] req0_addr, req0_wdata, req0_rdata;
  logic        req1_valid, req1_write, req1_ready, req1_rvalid;
  logic [63:0] req1_addr, req1_wdata, req1_rdata;
  logic [63:0] Mem_Addr, Write_Data, Read_Data;
  logic        MemWrite, MemRead;
`ifdef MEM_ALIGN_CHECK_EN
  logic        err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] mem [8] = '{64'd3, 64'd5, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};

  always #5 clk = ~clk;

  assign Read_Data = mem[Mem_Addr[5:3]];
  always @(posedge clk) if (MemWrite) mem[Mem_Addr[5:3]] <= Write_Data;

  data_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
    .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
    .req1_rdata(req1_rdata),
    .Mem_Addr(Mem_Addr), .Write_Data(Write_Data), .MemWrite(MemWrite), .MemRead(MemRead),
`ifdef MEM_ALIGN_CHECK_EN
    .err(err),
`endif
    .Read_Data(Read_Data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %0h", tag, got);
    end
  endtask

  // Starts at a negedge in IDLE, ends at the negedge of the following IDLE cycle.
  task automatic access(input int p, input logic w, input logic [63:0] a, input logic [63:0] d,
                        input logic [63:0] exp_rdata, input logic bad, input string tag);
    int waited = 0;
    if (p == 0) begin
      req0_valid = 1'b1; req0_write = w; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = 1'b1; req1_write = w; req1_addr = a; req1_wdata = d;
    end
    #1;
    while (!((p == 0) ? req0_ready : req1_ready) && waited < 10) begin
      @(negedge clk); #1; waited++;
    end
    check({tag, " ready"}, (p == 0) ? req0_ready : req1_ready, 64'd1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check({tag, " MemWrite"}, MemWrite, w && !bad);
    check({tag, " MemRead"}, MemRead, !w && !bad);
    if (!bad) check({tag, " Mem_Addr"}, Mem_Addr, a);
    if (w && !bad) check({tag, " Write_Data"}, Write_Data, d);
    @(negedge clk);
    check({tag, " rvalid"}, {req1_rvalid, req0_rvalid}, (p == 0) ? 2'b01 : 2'b10);
    check({tag, " strobes idle"}, {MemWrite, MemRead}, 2'b00);
    if (!w || bad) check({tag, " rdata"}, (p == 0) ? req0_rdata : req1_rdata, bad ? 64'd0 : exp_rdata);
`ifdef MEM_ALIGN_CHECK_EN
    check({tag, " err"}, err, bad);
`endif
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    req0_valid = 0; req0_write = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("reset rvalid", {req1_rvalid, req0_rvalid}, 2'b00);
    check("reset strobes", {MemWrite, MemRead}, 2'b00);
    check("reset Mem_Addr", Mem_Addr, 64'd0);
    check("reset Write_Data", Write_Data, 64'd0);
    check("reset rdata0", req0_rdata, 64'd0);
    check("reset rdata1", req1_rdata, 64'd0);

    access(0, 1'b0, 64'd8, 64'd0, 64'd5, 1'b0, "t1 ld0@8");

    access(1, 1'b1, 64'd16, 64'h0123_4567_89AB_CDEF, 64'd0, 1'b0, "t2 st1@16");
    access(1, 1'b0, 64'd16, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0, "t2 ld1@16");

    // Continuous dual requests after reset: port 0 first, then alternate.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req0_valid = 1; req0_write = 0; req0_addr = 64'd0;
    req1_valid = 1; req1_write = 0; req1_addr = 64'd8;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("t3 grant%0d ready", i), {req1_ready, req0_ready}, (i % 2) ? 2'b10 : 2'b01);
      @(negedge clk);
      check($sformatf("t3 grant%0d Mem_Addr", i), Mem_Addr, (i % 2) ? 64'd8 : 64'd0);
      @(negedge clk);
      check($sformatf("t3 grant%0d rvalid", i), {req1_rvalid, req0_rvalid}, (i % 2) ? 2'b10 : 2'b01);
      check($sformatf("t3 grant%0d rdata", i), (i % 2) ? req1_rdata : req0_rdata, (i % 2) ? 64'd5 : 64'd3);
      @(negedge clk);
    end
    req0_valid = 0;
    req1_valid = 0;

    // Reset lands on the ACCESS edge of a store: store commits, no response.
    req0_valid = 1; req0_write = 1; req0_addr = 64'd24; req0_wdata = 64'hAA;
    #1;
    check("t4 ready", req0_ready, 64'd1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 0;
    reset = 1'b1;
    check("t4 MemWrite", MemWrite, 64'd1);
    @(negedge clk);
    reset = 1'b0;
    check("t4 rvalid after reset", {req1_rvalid, req0_rvalid}, 2'b00);
    @(negedge clk);
    check("t4 rvalid next", {req1_rvalid, req0_rvalid}, 2'b00);
    access(0, 1'b0, 64'd24, 64'd0, 64'hAA, 1'b0, "t4 ld0@24");

    // Port 0 pulses valid only during another port's RESP cycle.
    req1_valid = 1; req1_write = 0; req1_addr = 64'd8;
    #1;
    check("t5 ready1", req1_ready, 64'd1);
    @(posedge clk);
    @(negedge clk);
    req1_valid = 0;
    @(negedge clk);
    req0_valid = 1; req0_write = 1; req0_addr = 64'd32; req0_wdata = 64'd77;
    #1;
    check("t5 rvalid1", {req1_rvalid, req0_rvalid}, 2'b10);
    check("t5 no ready in RESP", {req1_ready, req0_ready}, 2'b00);
    @(negedge clk);
    req0_valid = 0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t5 idle%0d strobes", i), {MemWrite, MemRead}, 2'b00);
      check($sformatf("t5 idle%0d rvalid", i), {req1_rvalid, req0_rvalid}, 2'b00);
      @(negedge clk);
    end
    check("t5 mem[32] untouched", mem[4], 64'd0);

`ifdef MEM_ALIGN_CHECK_EN
    access(0, 1'b0, 64'd3, 64'd0, 64'd0, 1'b1, "t6 ld0@3 bad");
    access(1, 1'b1, 64'd60, 64'hDEAD, 64'd0, 1'b1, "t6 st1@60 bad");
    check("t6 mem[56] untouched", mem[7], 64'd0);
    access(0, 1'b0, 64'd0, 64'd0, 64'd3, 1'b0, "t6 ld0@0");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
